alu_muldiv: RTL and testbench
=============================

# alu_muldiv

Parametrised, registered successor to the CPU54 single-cycle ALU. It executes the full ALU operation set with registered results and flags, and adds an iterative multiply/divide engine (MULT, MULTU, DIV, DIVU) with HI/LO result registers. Each operation runs under a start/busy/done handshake. The block sits in the execute stage; the control unit issues operations, and the stall logic watches busy.

## Interface
Parameters:
- WIDTH, 32: datapath width. Must be even, and a power of two ≥ 8.
- SHW, $clog2(WIDTH): width of the shift-amount field.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request an operation; accepted only when busy=0.
- op  in  5  operation code:
  - op[4]=0: ALU operation, with op[3:0] in aluc encoding.
  - op[4]=1: multiply/divide, with op[1:0] = 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  operand A (shift amount for shifts).
- b  in  WIDTH  operand B.
- busy  out  1  a multiply/divide is in progress.
- done  out  1  one-cycle pulse: r, flags and hi/lo are valid.
- r  out  WIDTH  result (lo for multiply/divide).
- hi, lo  out  WIDTH  multiply high/low half, or divide remainder/quotient.
- zero, carry, negative, overflow  out  1  registered flags.
- dz  out  1  the last division had divisor 0.

## Operation
- aluc encoding and results:
  - 0000 ADDU: carry = carry-out.
  - 0010 ADD: overflow = signed overflow.
  - 0001 SUBU: carry = borrow, i.e. a<b unsigned.
  - 0011 SUB: overflow = signed overflow.
  - 0100 AND, 0101 OR, 0110 XOR, 0111 NOR.
  - 100x LUI: r = {b[WIDTH/2-1:0], zeros}.
  - 1010 SLTU: unsigned a<b.
  - 1011 SLT: signed a<b.
  - 1100 SRA and 1101 SRL: b shifted by a[SHW-1:0].
  - 111x SLL: b shifted by a[SHW-1:0].
- Shift carry = last bit shifted out. A shift amount of 0 gives carry=0.
- Flags not listed for an operation are 0. For every ALU operation, zero = (r==0) and negative = r[WIDTH-1].
- Multiply/divide core:
  - Signed operations convert both operands to magnitudes, run an unsigned iteration, then fix signs.
  - Multiply uses shift-add, one bit per cycle, producing a 2·WIDTH-bit product {hi,lo}.
  - Divide uses restoring division, one bit per cycle: lo = quotient, hi = remainder.
  - Quotient is negative iff operand signs differ; remainder takes the dividend's sign.
- Boundary cases:
  - Divide by zero: lo = all ones, hi = a, dz=1.
  - MIN / -1: lo = MIN, hi = 0, overflow=1.
- Multiply/divide flags: zero = ({hi,lo}==0), negative = hi[WIDTH-1] for MULT/DIV only, carry=0. dz clears on any other multiply/divide.
- Register retention:
  - hi/lo change only at completion of a multiply/divide.
  - r and the flags change only on done.
  - All outputs hold between operations.

## Timing
- Reset (asynchronous, any time, including mid-iteration):
  - busy=0, done=0, r=hi=lo=0, all flags and dz = 0.
  - Any in-flight operation is discarded.
- States: IDLE, RUN, FIN.
  - IDLE: start with op[4]=0 latches the ALU result at edge E0. done=1 during the E0–E1 cycle, busy stays 0, and the state stays IDLE. This gives 1-cycle latency.
  - IDLE: start with op[4]=1 captures operands and magnitudes at E0, sets busy=1 and clears the iteration counter. Next state is RUN.
  - RUN: one iteration per edge E1..E_WIDTH. The counter reaches WIDTH-1, then the state moves to FIN.
  - FIN: at E_WIDTH+1, sign fixes are applied and hi/lo/r/flags are written. busy=0, done=1 for one cycle, and the state returns to IDLE.
- Multiply/divide latency is WIDTH+1 cycles from the start edge to done (33 at WIDTH=32).
- start while busy=1 is ignored with no side effects; the issuer must hold or reissue it.
- start in the same cycle as done (busy already 0) is accepted. Back-to-back operations are legal.
- Operand inputs may change after E0; the captured copies are used.

## Structure
- Package alu_pkg holds:
  - the aluc localparams (ALU_ADDU … ALU_SLL);
  - the MD_MULT/MD_MULTU/MD_DIV/MD_DIVU codes;
  - the state enum (S_IDLE, S_RUN, S_FIN);
  - the default WIDTH.
- Sub-module muldiv_iter contains the iteration datapath: partial product/remainder registers, counter and sign fixes. It is parameterised by WIDTH.
- The top level contains the combinational ALU, the output registers and the FSM.

## Test plan
- ALU flags:
  - ADD a=0x7FFFFFFF, b=1 → r=0x80000000, overflow=1, negative=1, done one cycle after start, busy never high.
  - SUBU a=1, b=2 → r=0xFFFFFFFF, carry=1.
- Shifts:
  - SRA a=4, b=0x80000010 → r=0xF8000001, carry=0.
  - SLL a=1, b=0x80000000 → r=0, zero=1, carry=1.
  - SRL a=0 → carry=0.
- Multiply:
  - MULT a=-3, b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB, done exactly 33 cycles after start.
  - MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=1.
- Divide:
  - DIV a=-7, b=2 → lo=-3, hi=-1.
  - DIVU a=5, b=0 → lo=0xFFFFFFFF, hi=5, dz=1.
  - DIV 0x80000000 / -1 → lo=0x80000000, hi=0, overflow=1.
- Handshake:
  - start pulsed at cycles 5 and 10 of a MULT → second request ignored, hi/lo reflect the first operation only.
  - start held high at done → next operation accepted that cycle.
- Reset mid-DIV at cycle 12 → busy, done, hi, lo all 0 immediately (asynchronously). A new MULTU after release completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the registered ALU with iterative multiply/divide:
// ALU function codes, multiply/divide codes, sequencer states, default width.
package alu_pkg;
  localparam int DEFAULT_WIDTH = 32;

  localparam logic [3:0] ALU_ADDU = 4'b0000;
  localparam logic [3:0] ALU_SUBU = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1100;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [3:0] ALU_SLL  = 4'b1110;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;
endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier / restoring divider on operand
// magnitudes, with sign fix-up and the divide-by-zero result applied on output.
module muldiv_iter import alu_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic             signed_o,
  output logic             dz_o,
  output logic             ovf_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d, a_q, a_d;
  logic               is_div_q, is_div_d, signed_q, signed_d;
  logic               negp_q, negp_d, negr_q, negr_d, dz_q, dz_d, ovf_q, ovf_d;

  logic               sa, sb;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  assign sa       = ~op_i[0] & a_i[WIDTH-1];
  assign sb       = ~op_i[0] & b_i[WIDTH-1];
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
  assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, mag_b_q};

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mag_b_d  = mag_b_q;
    a_d      = a_q;
    is_div_d = is_div_q;
    signed_d = signed_q;
    negp_d   = negp_q;
    negr_d   = negr_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    if (load_i) begin
      cnt_d    = '0;
      acc_d    = {{WIDTH{1'b0}}, (sa ? -a_i : a_i)};
      mag_b_d  = sb ? -b_i : b_i;
      a_d      = a_i;
      is_div_d = op_i[1];
      signed_d = ~op_i[0];
      negp_d   = sa ^ sb;
      negr_d   = sa;
      dz_d     = op_i[1] & (b_i == '0);
      ovf_d    = (op_i == MD_DIV) & (a_i == {1'b1, {(WIDTH-1){1'b0}}}) & (&b_i);
    end else if (step_i) begin
      cnt_d = cnt_q + 1'b1;
      if (is_div_q)
        acc_d = {(div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
      else
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Iteration datapath carries no reset; it is always reloaded before use.
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    mag_b_q  <= mag_b_d;
    a_q      <= a_d;
    is_div_q <= is_div_d;
    signed_q <= signed_d;
    negp_q   <= negp_d;
    negr_q   <= negr_d;
    dz_q     <= dz_d;
    ovf_q    <= ovf_d;
  end

  always_comb begin
    prod = negp_q ? -acc_q : acc_q;
    quo  = negp_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem  = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (!is_div_q) begin
      hi_o = prod[2*WIDTH-1:WIDTH];
      lo_o = prod[WIDTH-1:0];
    end else if (dz_q) begin
      hi_o = a_q;
      lo_o = '1;
    end else begin
      hi_o = rem;
      lo_o = quo;
    end
  end

  assign last_o   = (cnt_q == SHW'(WIDTH-1));
  assign signed_o = signed_q;
  assign dz_o     = dz_q;
  assign ovf_o    = ovf_q;
endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU with registered result/flags and an iterative
// multiply/divide engine behind a start/busy/done handshake.
module alu_muldiv import alu_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic             dz
);
  state_e           state_q, state_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] r_q, r_d, hi_q, hi_d, lo_q, lo_d;
  logic             zero_q, zero_d, carry_q, carry_d, neg_q, neg_d;
  logic             ovf_q, ovf_d, dz_q, dz_d;

  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH:0]   add_w, sub_w;
  logic [SHW-1:0]   sh, sh_m1, sh_l;
  logic             rcarry;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c, alu_v;

  logic             md_load, md_step, md_last, md_signed, md_dz, md_ovf;
  logic [WIDTH-1:0] md_hi, md_lo;

  assign a_s    = a;
  assign b_s    = b;
  assign add_w  = {1'b0, a} + {1'b0, b};
  assign sub_w  = {1'b0, a} - {1'b0, b};
  assign sh     = a[SHW-1:0];
  assign sh_m1  = sh - 1'b1;
  assign sh_l   = SHW'(0) - sh;
  assign rcarry = (sh != '0) & b[sh_m1];

  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op[3:0])
      ALU_ADDU: begin alu_r = add_w[WIDTH-1:0]; alu_c = add_w[WIDTH]; end
      ALU_ADD: begin
        alu_r = add_w[WIDTH-1:0];
        alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUBU: begin alu_r = sub_w[WIDTH-1:0]; alu_c = sub_w[WIDTH]; end
      ALU_SUB: begin
        alu_r = sub_w[WIDTH-1:0];
        alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: alu_r = a & b;
      ALU_OR:  alu_r = a | b;
      ALU_XOR: alu_r = a ^ b;
      ALU_NOR: alu_r = ~(a | b);
      ALU_LUI, ALU_LUI | 4'b0001: alu_r = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      ALU_SLTU: alu_r = {{(WIDTH-1){1'b0}}, sub_w[WIDTH]};
      ALU_SLT:  alu_r = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      ALU_SRA: begin alu_r = b_s >>> sh; alu_c = rcarry; end
      ALU_SRL: begin alu_r = b >> sh;    alu_c = rcarry; end
      ALU_SLL, ALU_SLL | 4'b0001: begin
        alu_r = b << sh;
        alu_c = (sh != '0) & b[sh_l];
      end
      default: alu_r = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    r_d     = r_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    md_load = 1'b0;
    md_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !op[4]) begin
          r_d     = alu_r;
          zero_d  = (alu_r == '0);
          neg_d   = alu_r[WIDTH-1];
          carry_d = alu_c;
          ovf_d   = alu_v;
          done_d  = 1'b1;
        end else if (start) begin
          md_load = 1'b1;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        md_step = 1'b1;
        if (md_last) state_d = S_FIN;
      end
      S_FIN: begin
        hi_d    = md_hi;
        lo_d    = md_lo;
        r_d     = md_lo;
        zero_d  = ({md_hi, md_lo} == '0);
        neg_d   = md_signed & md_hi[WIDTH-1];
        carry_d = 1'b0;
        ovf_d   = md_ovf;
        dz_d    = md_dz;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      r_q     <= r_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  muldiv_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .load_i   (md_load),
    .step_i   (md_step),
    .op_i     (op[1:0]),
    .a_i      (a),
    .b_i      (b),
    .last_o   (md_last),
    .signed_o (md_signed),
    .dz_o     (md_dz),
    .ovf_o    (md_ovf),
    .hi_o     (md_hi),
    .lo_o     (md_lo)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign r        = r_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign negative = neg_q;
  assign overflow = ovf_q;
  assign dz       = dz_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: ALU results/flags, multiply/divide results,
// latency, handshake corner cases and asynchronous reset mid-operation.
module tb_alu_muldiv;
  import alu_pkg::*;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [4:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, zero, carry, negative, overflow, dz;
  logic [W-1:0] r, hi, lo;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int lat, t0;
  logic b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .r(r), .hi(hi), .lo(lo),
    .zero(zero), .carry(carry), .negative(negative), .overflow(overflow), .dz(dz)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic ez, ec, en, ev);
    check({tag, ".zero"},     32'(zero),     32'(ez));
    check({tag, ".carry"},    32'(carry),    32'(ec));
    check({tag, ".negative"}, 32'(negative), 32'(en));
    check({tag, ".overflow"}, 32'(overflow), 32'(ev));
  endtask

  // Drives one start cycle; afterwards operands are scrambled to prove capture.
  task automatic issue(input logic [4:0] o, input logic [31:0] av, input logic [31:0] bv,
                       output int ts, output logic busy_e0);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; a = 32'hA5A5_5A5A; b = 32'h5A5A_A5A5;
    ts = cyc;
    busy_e0 = busy;
  endtask

  task automatic wait_done(input int ts, output int l);
    l = -1;
    for (int i = 0; i < 48 && l < 0; i++) begin
      if (done) l = cyc - ts;
      else begin @(posedge clk); #1; end
    end
  endtask

  task automatic run(input logic [4:0] o, input logic [31:0] av, input logic [31:0] bv,
                     output int l, output logic busy_e0);
    int ts;
    issue(o, av, bv, ts, busy_e0);
    wait_done(ts, l);
  endtask

  function automatic logic [4:0] alu_op(input logic [3:0] c);
    return {1'b0, c};
  endfunction

  function automatic logic [4:0] md_op(input logic [1:0] c);
    return {3'b100, c};
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    #12;
    check("rst.busy", 32'(busy), 0);
    check("rst.done", 32'(done), 0);
    check("rst.r", r, 0);
    check("rst.hi", hi, 0);
    check("rst.lo", lo, 0);
    check("rst.dz", 32'(dz), 0);
    check_flags("rst", 0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;

    run(alu_op(ALU_ADD), 32'h7FFF_FFFF, 32'h1, lat, b0);
    check("add.lat", lat, 0);
    check("add.busy", 32'(b0), 0);
    check("add.r", r, 32'h8000_0000);
    check_flags("add", 0, 0, 1, 1);
    @(posedge clk); #1;
    check("add.done_pulse", 32'(done), 0);
    check("add.busy_after", 32'(busy), 0);

    run(alu_op(ALU_SUBU), 32'h1, 32'h2, lat, b0);
    check("subu.r", r, 32'hFFFF_FFFF);
    check_flags("subu", 0, 1, 1, 0);
    run(alu_op(ALU_ADDU), 32'hFFFF_FFFF, 32'h1, lat, b0);
    check("addu.r", r, 32'h0);
    check_flags("addu", 1, 1, 0, 0);
    run(alu_op(ALU_SUB), 32'h8000_0000, 32'h1, lat, b0);
    check("sub.r", r, 32'h7FFF_FFFF);
    check_flags("sub", 0, 0, 0, 1);
    run(alu_op(ALU_SRA), 32'h4, 32'h8000_0010, lat, b0);
    check("sra.r", r, 32'hF800_0001);
    check_flags("sra", 0, 0, 1, 0);
    run(alu_op(ALU_SLL), 32'h1, 32'h8000_0000, lat, b0);
    check("sll.r", r, 32'h0);
    check_flags("sll", 1, 1, 0, 0);
    run(alu_op(ALU_SRL), 32'h0, 32'h1234_5678, lat, b0);
    check("srl0.r", r, 32'h1234_5678);
    check("srl0.carry", 32'(carry), 0);
    run(alu_op(ALU_SRL), 32'h4, 32'h0000_0018, lat, b0);
    check("srl4.r", r, 32'h1);
    check("srl4.carry", 32'(carry), 1);
    run(alu_op(ALU_SLT), 32'hFFFF_FFFF, 32'h1, lat, b0);
    check("slt.r", r, 32'h1);
    run(alu_op(ALU_SLTU), 32'hFFFF_FFFF, 32'h1, lat, b0);
    check("sltu.r", r, 32'h0);
    check("sltu.zero", 32'(zero), 1);
    run(5'b01001, 32'h0, 32'h1234_ABCD, lat, b0);
    check("lui.r", r, 32'hABCD_0000);
    run(alu_op(ALU_NOR), 32'h0, 32'h0, lat, b0);
    check("nor.r", r, 32'hFFFF_FFFF);
    run(alu_op(ALU_XOR), 32'h0000_F0F0, 32'h0000_FF00, lat, b0);
    check("xor.r", r, 32'h0000_0FF0);
    check("alu.hi_hold", hi, 0);
    check("alu.lo_hold", lo, 0);

    run(md_op(MD_MULT), 32'hFFFF_FFFD, 32'h7, lat, b0);
    check("mult.busy", 32'(b0), 1);
    check("mult.lat", lat, 33);
    check("mult.hi", hi, 32'hFFFF_FFFF);
    check("mult.lo", lo, 32'hFFFF_FFEB);
    check("mult.r", r, 32'hFFFF_FFEB);
    check_flags("mult", 0, 0, 1, 0);
    check("mult.busy_done", 32'(busy), 0);
    run(md_op(MD_MULTU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, b0);
    check("multu.hi", hi, 32'hFFFF_FFFE);
    check("multu.lo", lo, 32'h1);
    check("multu.neg", 32'(negative), 0);
    run(md_op(MD_DIV), 32'hFFFF_FFF9, 32'h2, lat, b0);
    check("div.lat", lat, 33);
    check("div.lo", lo, 32'hFFFF_FFFD);
    check("div.hi", hi, 32'hFFFF_FFFF);
    check("div.neg", 32'(negative), 1);
    run(md_op(MD_DIVU), 32'h5, 32'h0, lat, b0);
    check("divu0.lo", lo, 32'hFFFF_FFFF);
    check("divu0.hi", hi, 32'h5);
    check("divu0.dz", 32'(dz), 1);
    check_flags("divu0", 0, 0, 0, 0);
    run(alu_op(ALU_ADDU), 32'h1, 32'h1, lat, b0);
    check("dzhold.r", r, 32'h2);
    check("dzhold.dz", 32'(dz), 1);
    check("dzhold.hi", hi, 32'h5);
    run(md_op(MD_DIV), 32'h8000_0000, 32'hFFFF_FFFF, lat, b0);
    check("divmin.lo", lo, 32'h8000_0000);
    check("divmin.hi", hi, 32'h0);
    check("divmin.dz", 32'(dz), 0);
    check_flags("divmin", 0, 0, 0, 1);

    // Extra starts while busy must leave the first multiply untouched.
    issue(md_op(MD_MULT), 32'h6, 32'h7, t0, b0);
    repeat (4) @(posedge clk);
    @(negedge clk); start = 1'b1; op = md_op(MD_MULTU); a = 32'd100; b = 32'd100;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); start = 1'b1; op = md_op(MD_DIVU); a = 32'd99; b = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    wait_done(t0, lat);
    check("hs.lat", lat, 33);
    check("hs.hi", hi, 32'h0);
    check("hs.lo", lo, 32'd42);
    @(posedge clk); #1;
    check("hs.idle_busy", 32'(busy), 0);
    check("hs.idle_done", 32'(done), 0);

    // Start held high through done: the waiting ALU op lands right after.
    @(negedge clk); start = 1'b1; op = md_op(MD_MULT); a = 32'd2; b = 32'd3;
    @(posedge clk); #1;
    t0 = cyc; op = alu_op(ALU_ADDU); a = 32'd5; b = 32'd6;
    wait_done(t0, lat);
    check("b2b.lat", lat, 33);
    check("b2b.lo", lo, 32'd6);
    check("b2b.r1", r, 32'd6);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b.done2", 32'(done), 1);
    check("b2b.r2", r, 32'd11);
    check("b2b.lo_hold", lo, 32'd6);
    check("b2b.busy", 32'(busy), 0);

    issue(md_op(MD_DIV), 32'd100, 32'd7, t0, b0);
    repeat (12) @(posedge clk);
    #3;
    check("rstmid.busy_before", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("rstmid.busy", 32'(busy), 0);
    check("rstmid.done", 32'(done), 0);
    check("rstmid.hi", hi, 0);
    check("rstmid.lo", lo, 0);
    check("rstmid.r", r, 0);
    @(negedge clk); rst = 1'b0;
    run(md_op(MD_MULTU), 32'd9, 32'd9, lat, b0);
    check("post.lat", lat, 33);
    check("post.lo", lo, 32'd81);
    check("post.hi", hi, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
